// File: rtl/mux4_1_arb.sv
// Round-robin 4:1 merge onto one registered, channel-tagged stream; one-cycle accept-to-output latency.
// The output register refills in the same cycle it drains; while it is full and stalled, no input is accepted.
module mux4_1_arb #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         in_valid,
  input  logic [4*WIDTH-1:0] in_data,
  output logic [3:0]         in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         out_sel,
  input  logic               out_ready
);

  logic [1:0]       ptr_q, ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]       out_sel_q, out_sel_d;

  logic             load_ok;
  logic             grant_vld;
  logic [1:0]       grant_idx;
  logic [1:0]       scan_idx;
  logic [WIDTH-1:0] ch_data [4];

  assign load_ok = ~out_valid_q | out_ready;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      ch_data[i] = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Scan from farthest to nearest so the channel closest to ptr is the last to write the grant.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = 2'd0;
    scan_idx  = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      scan_idx = ptr_q + 2'(k);
      if (in_valid[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  assign in_ready = (grant_vld && load_ok && !rst) ? (4'b0001 << grant_idx) : 4'b0000;

  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (grant_vld && load_ok) begin
      out_valid_d = 1'b1;
      out_data_d  = ch_data[grant_idx];
      out_sel_d   = grant_idx;
      ptr_d       = grant_idx + 2'd1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= 2'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= 2'd0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux4_1_arb.sv
// Bench for mux4_1_arb: directed scenarios followed by random traffic, checked against a queue-free behavioural model.
module tb_mux4_1_arb;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   in_valid;
  logic [4*W-1:0] in_data;
  logic [3:0]   in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   out_sel;
  logic         out_ready;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int           m_ptr;
  logic         m_ov;
  logic [W-1:0] m_od;
  int           m_os;
  int           m_acc;

  mux4_1_arb #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0;
    m_ov  = 1'b0;
    m_od  = '0;
    m_os  = 0;
    m_acc = -1;
  endtask

  task automatic set_ch(input int c, input logic [W-1:0] d);
    in_data[c*W +: W] = d;
  endtask

  // Called at a falling edge with inputs already set; returns at the next falling edge.
  task automatic tick();
    int g;
    int c;
    logic lok;
    logic [3:0] er;
    #1;
    g = -1;
    for (int k = 0; k < 4; k++) begin
      c = (m_ptr + k) % 4;
      if (g < 0 && in_valid[c]) g = c;
    end
    lok = !m_ov || out_ready;
    er  = (g >= 0 && lok) ? 4'(1 << g) : 4'b0000;
    check("in_ready", 32'(in_ready), 32'(er));
    @(posedge clk);
    m_acc = -1;
    if (g >= 0 && lok) begin
      m_od  = in_data[g*W +: W];
      m_os  = g;
      m_ov  = 1'b1;
      m_ptr = (g + 1) % 4;
      m_acc = g;
    end else if (m_ov && out_ready) begin
      m_ov = 1'b0;
    end
    #1;
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("out_data", 32'(out_data), 32'(m_od));
    check("out_sel", 32'(out_sel), 32'(m_os));
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0] wrap_exp [4];
    logic [W-1:0] rd;
    wrap_exp[0] = 2'd0; wrap_exp[1] = 2'd3; wrap_exp[2] = 2'd0; wrap_exp[3] = 2'd3;

    rst = 1'b1;
    in_valid = 4'b0000;
    in_data = '0;
    out_ready = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_sel", 32'(out_sel), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single channel streaming on ch1
    for (int i = 0; i < 3; i++) begin
      in_valid = 4'b0010;
      set_ch(1, 8'h10 + 8'(i));
      tick();
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_sel", 32'(out_sel), 32'd1);
      check("stream_data", 32'(out_data), 32'h10 + 32'(i));
    end

    // Idle drain
    in_valid = 4'b0000;
    tick();
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_hold", 32'(out_data), 32'h12);

    // Reset mid-stream with a beat in the register
    in_valid = 4'b0001;
    set_ch(0, 8'h77);
    tick();
    in_valid = 4'b0101;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'd0);
    check("midrst_out_sel", 32'(out_sel), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    in_valid = 4'b0100;
    set_ch(2, 8'hA5);
    tick();
    check("postrst_valid", 32'(out_valid), 32'd1);
    check("postrst_data", 32'(out_data), 32'hA5);
    check("postrst_sel", 32'(out_sel), 32'd2);

    // Round robin, all four valid
    in_valid = 4'b0000;
    pulse_reset();
    for (int c = 0; c < 4; c++) set_ch(c, 8'h40 + 8'(c));
    in_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rr_sel", 32'(out_sel), 32'(i % 4));
      check("rr_data", 32'(out_data), 32'h40 + 32'(i % 4));
    end

    // Pointer wrap and skip: ch0 and ch3 only
    in_valid = 4'b0000;
    pulse_reset();
    set_ch(0, 8'h50);
    set_ch(3, 8'h53);
    in_valid = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("wrap_sel", 32'(out_sel), 32'(wrap_exp[i]));
    end

    // Backpressure with ch0 and ch2 valid and a beat already held
    in_valid = 4'b0101;
    set_ch(0, 8'h60);
    set_ch(2, 8'h62);
    tick();
    set_ch(0, 8'h61);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_data", 32'(out_data), 32'h60);
    end
    out_ready = 1'b1;
    tick();
    check("bp_next_sel", 32'(out_sel), 32'd2);
    in_valid = 4'b0001;
    tick();
    check("bp_ch0_data", 32'(out_data), 32'h61);

    // Random traffic honouring the hold-until-ready source rule
    in_valid = 4'b0000;
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < 4; c++) begin
        if (!in_valid[c] && ($urandom_range(0, 1) == 1)) begin
          rd = 8'($urandom);
          set_ch(c, rd);
          in_valid[c] = 1'b1;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (m_acc >= 0) in_valid[m_acc] = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
